// File: rtl/win_change_sched_pkg.sv
`default_nettype none
// ============================================================================
// win_change_sched_pkg : shared types and helpers for the window-change scheduler
// Revision 1.0
// ============================================================================
package win_change_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    function automatic int idw_calc(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Requester count is capped at 16, so a 16-bit popcount covers every build.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/win_change_rr_pick.sv
`default_nettype none
// ============================================================================
// win_change_rr_pick : combinational round-robin picker, scans from last+1
// Revision 1.0
// ============================================================================
module win_change_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last,
    output logic               valid,
    output logic [IDW-1:0]     winner
);

    int w_idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        w_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!valid) begin
                w_idx = (int'(last) + k) % NUM_REQ;
                if (req[w_idx]) begin
                    valid  = 1'b1;
                    winner = IDW'(w_idx);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/win_change_sched.sv
`default_nettype none
// ============================================================================
// win_change_sched : round-robin shared window-change checker with drop count
// Revision 1.0
// ============================================================================
module win_change_sched
    import win_change_sched_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  WIDTH   = 8,
    parameter int  MAX_WIN = 255,
    parameter int  CNT_W   = 16,
    localparam int IDW     = idw_calc(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       start_event,
    input  logic [NUM_REQ-1:0]       end_event,
    input  logic [NUM_REQ*WIDTH-1:0] test_expr,
    output logic                     window,
    output logic [IDW-1:0]           grant_id,
    output logic                     fire,
    output logic [IDW-1:0]           fire_id,
    output logic                     timeout,
    output logic [IDW-1:0]           timeout_id,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int C_CTR_W = $clog2(MAX_WIN + 1);

    state_t             r_state;
    logic [IDW-1:0]     r_last;
    logic [WIDTH-1:0]   r_baseline;
    logic               r_changed;
    logic [C_CTR_W-1:0] r_counter;

    logic               w_pick_valid;
    logic [IDW-1:0]     w_pick_id;
    logic [WIDTH-1:0]   w_cur_expr;
    logic               w_diff;
    logic [4:0]         w_start_cnt;
    logic [4:0]         w_drop_add;
    logic [CNT_W:0]     w_drop_sum;
    logic [CNT_W-1:0]   w_drop_next;

    win_change_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req    (start_event),
        .last   (r_last),
        .valid  (w_pick_valid),
        .winner (w_pick_id)
    );

    always_comb begin
        w_cur_expr = test_expr[int'(grant_id)*WIDTH +: WIDTH];
        // if/else rather than a ternary so an X operand is treated as a change
        if (w_cur_expr == r_baseline) begin
            w_diff = 1'b0;
        end else begin
            w_diff = 1'b1;
        end
        w_start_cnt = popcount16(16'(start_event));
        if (r_state == IDLE) begin
            w_drop_add = w_pick_valid ? (w_start_cnt - 5'd1) : 5'd0;
        end else begin
            w_drop_add = w_start_cnt;
        end
        w_drop_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(w_drop_add);
        w_drop_next = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_last     <= IDW'(NUM_REQ - 1);
            r_baseline <= '0;
            r_changed  <= 1'b0;
            r_counter  <= '0;
            window     <= 1'b0;
            grant_id   <= '0;
            fire       <= 1'b0;
            fire_id    <= '0;
            timeout    <= 1'b0;
            timeout_id <= '0;
            drop_cnt   <= '0;
        end else begin
            fire     <= 1'b0;
            timeout  <= 1'b0;
            drop_cnt <= w_drop_next;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        grant_id   <= w_pick_id;
                        r_last     <= w_pick_id;
                        r_baseline <= test_expr[int'(w_pick_id)*WIDTH +: WIDTH];
                        r_changed  <= 1'b0;
                        r_counter  <= '0;
                        window     <= 1'b1;
                        r_state    <= OPEN;
                    end
                end
                OPEN: begin
                    if (r_counter != '1) begin
                        r_counter <= r_counter + C_CTR_W'(1);
                    end
                    if (w_diff) begin
                        r_changed <= 1'b1;
                    end
                    // End has priority over a timeout landing on the same cycle.
                    if (end_event[grant_id]) begin
                        window  <= 1'b0;
                        r_state <= IDLE;
                        if (!r_changed && !w_diff) begin
                            fire    <= 1'b1;
                            fire_id <= grant_id;
                        end
                    end else if (r_counter == C_CTR_W'(MAX_WIN - 1)) begin
                        timeout    <= 1'b1;
                        timeout_id <= grant_id;
                        window     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
